// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature encoder counter:
// step classification codes and the saturating accumulator add.
package quad_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_POS  = 2'b01,
    STEP_NEG  = 2'b10,
    STEP_ERR  = 2'b11
  } step_e;

  // Symmetric clamp to +/-(2^(w-1)-1); callers keep w <= 31 so a+b cannot overflow.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] lim;
    logic signed [31:0] sum;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    sum = a + b;
    if (sum > lim) return lim;
    if (sum < -lim) return -lim;
    return sum;
  endfunction

endpackage

// File: rtl/quad_in_filt.sv
// Input conditioning for one encoder pin: multi-flop synchroniser followed by a
// glitch filter that only accepts a new level after FILT_LEN consecutive clocks.
module quad_in_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   s;

  // Any return to the filtered level restarts the qualification count.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    s      = sync_q[SYNC_STAGES-1];
    filt_d = filt_q;
    cnt_d  = '0;
    if (s != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) filt_d = s;
      else                            cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quad_enc_counter.sv
// 4x quadrature position counter with index zeroing, preload, illegal-transition
// tracking and windowed velocity measurement; one instance per wheel.
module quad_enc_counter
  import quad_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int VEL_W       = 16,
  parameter int VEL_WIN     = 50000,
  parameter int DIR_INV     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             quadA,
  input  logic             quadB,
  input  logic             quadI,
  input  logic             idx_clr_en,
  input  logic             cnt_load,
  input  logic [CNT_W-1:0] cnt_load_val,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             idx_seen,
  output logic             err_sticky,
  output logic [7:0]       err_cnt,
  output logic [VEL_W-1:0] vel,
  output logic             vel_valid
);

  localparam int   WIN_W = $clog2(VEL_WIN);
  localparam logic INV   = (DIR_INV != 0);

  logic fa, fb, fi;

  quad_in_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .pin_i(quadA), .filt_o(fa));
  quad_in_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .pin_i(quadB), .filt_o(fb));
  quad_in_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_i (
    .clk(clk), .rst_n(rst_n), .pin_i(quadI), .filt_o(fi));

  logic [1:0]              ab_prev_q, ab_prev_d;
  logic                    idx_prev_q, idx_prev_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    dir_q, dir_d;
  logic                    step_q, step_d;
  logic                    idx_seen_q, idx_seen_d;
  logic                    err_sticky_q, err_sticky_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [VEL_W-1:0]        vel_q, vel_d;
  logic                    vel_valid_q, vel_valid_d;
  logic signed [VEL_W-1:0] acc_q, acc_d;
  logic [WIN_W-1:0]        win_q, win_d;

  step_e              step_code;
  logic               idx_rise;
  logic signed [31:0] step_delta;
  logic signed [31:0] acc_sum;

  // Direction comes from the new A against the old B; both bits flipping is a missed state.
  always_comb begin
    step_code = STEP_NONE;
    case ({fa, fb} ^ ab_prev_q)
      2'b00:   step_code = STEP_NONE;
      2'b11:   step_code = STEP_ERR;
      default: step_code = ((fa ^ ab_prev_q[0]) ^ INV) ? STEP_POS : STEP_NEG;
    endcase
    idx_rise   = fi & ~idx_prev_q;
    step_delta = (step_code == STEP_POS) ? 32'sd1 :
                 (step_code == STEP_NEG) ? -32'sd1 : 32'sd0;

    ab_prev_d  = {fa, fb};
    idx_prev_d = fi;
    idx_seen_d = idx_rise;
    step_d     = (step_code == STEP_POS) || (step_code == STEP_NEG);
    dir_d      = (step_code == STEP_POS) ? 1'b1 :
                 (step_code == STEP_NEG) ? 1'b0 : dir_q;

    count_d = count_q;
    if (cnt_load)                     count_d = cnt_load_val;
    else if (idx_rise && idx_clr_en)  count_d = '0;
    else if (step_code == STEP_POS)   count_d = count_q + CNT_W'(1);
    else if (step_code == STEP_NEG)   count_d = count_q - CNT_W'(1);

    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (err_clr) begin
      err_sticky_d = (step_code == STEP_ERR);
      err_cnt_d    = (step_code == STEP_ERR) ? 8'd1 : 8'd0;
    end else if (step_code == STEP_ERR) begin
      err_sticky_d = 1'b1;
      err_cnt_d    = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
    end

    // The closing cycle of a window folds its own step into the published result.
    acc_sum     = sat_add(32'(acc_q), step_delta, VEL_W);
    vel_d       = vel_q;
    vel_valid_d = 1'b0;
    if (win_q == WIN_W'(VEL_WIN - 1)) begin
      vel_d       = VEL_W'(acc_sum);
      vel_valid_d = 1'b1;
      acc_d       = '0;
      win_d       = '0;
    end else begin
      acc_d = VEL_W'(acc_sum);
      win_d = win_q + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_prev_q    <= '0;
      idx_prev_q   <= 1'b0;
      count_q      <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      idx_seen_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      vel_q        <= '0;
      vel_valid_q  <= 1'b0;
      acc_q        <= '0;
      win_q        <= '0;
    end else begin
      ab_prev_q    <= ab_prev_d;
      idx_prev_q   <= idx_prev_d;
      count_q      <= count_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      idx_seen_q   <= idx_seen_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      vel_q        <= vel_d;
      vel_valid_q  <= vel_valid_d;
      acc_q        <= acc_d;
      win_q        <= win_d;
    end
  end

  assign count      = count_q;
  assign dir        = dir_q;
  assign step       = step_q;
  assign idx_seen   = idx_seen_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign vel        = vel_q;
  assign vel_valid  = vel_valid_q;

endmodule

// File: tb/tb_quad_enc_counter.sv
// Bench for quad_enc_counter: three instances (default, inverted sense, short
// velocity window) share the pins and are checked against a position-based model.
module tb_quad_enc_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        quadA = 1'b0, quadB = 1'b0, quadI = 1'b0;
  logic        idx_clr_en = 1'b0, cnt_load = 1'b0, err_clr = 1'b0;
  logic [31:0] cnt_load_val = '0;

  logic [31:0] count0, count1, count2;
  logic        dir0, dir1, dir2, step0, step1, step2, idx0, idx1, idx2;
  logic        errs0, errs1, errs2, velv0, velv1, velv2;
  logic [7:0]  errc0, errc1, errc2;
  logic [15:0] vel0, vel1;
  logic [3:0]  vel2;

  always #5 clk = ~clk;

  quad_enc_counter dut (
    .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .quadI(quadI),
    .idx_clr_en(idx_clr_en), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .err_clr(err_clr), .count(count0), .dir(dir0), .step(step0), .idx_seen(idx0),
    .err_sticky(errs0), .err_cnt(errc0), .vel(vel0), .vel_valid(velv0));

  quad_enc_counter #(.DIR_INV(1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .quadI(quadI),
    .idx_clr_en(idx_clr_en), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .err_clr(err_clr), .count(count1), .dir(dir1), .step(step1), .idx_seen(idx1),
    .err_sticky(errs1), .err_cnt(errc1), .vel(vel1), .vel_valid(velv1));

  quad_enc_counter #(.VEL_WIN(100), .VEL_W(4)) dut_vel (
    .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .quadI(quadI),
    .idx_clr_en(idx_clr_en), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .err_clr(err_clr), .count(count2), .dir(dir2), .step(step2), .idx_seen(idx2),
    .err_sticky(errs2), .err_cnt(errc2), .vel(vel2), .vel_valid(velv2));

  int checks = 0;
  int failures = 0;
  int step_pulses = 0;
  int idx_pulses = 0;

  // Reference model: encoder position in quarter-cycles, not pin-level logic.
  logic [1:0]  model_ab = 2'b00;
  logic [31:0] model_count = '0;
  logic [31:0] model_inv = '0;
  logic        model_dir = 1'b0;
  logic        model_sticky = 1'b0;
  int          model_err = 0;
  int          model_steps = 0;
  int          model_idx = 0;
  int          model_win = 0;

  always @(negedge clk) begin
    if (step0 === 1'b1) step_pulses++;
    if (idx0 === 1'b1) idx_pulses++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected end before 1ms");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int gpos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] abAt(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [3:0] clampVel(input int n);
    int c;
    c = (n > 7) ? 7 : ((n < -7) ? -7 : n);
    return c[3:0];
  endfunction

  task automatic modelApply(input logic [1:0] ab);
    int d;
    d = (gpos(ab) - gpos(model_ab)) & 3;
    if (d == 1) begin
      model_count = model_count + 32'd1;
      model_inv   = model_inv - 32'd1;
      model_dir   = 1'b1;
      model_steps++;
      model_win++;
    end else if (d == 3) begin
      model_count = model_count - 32'd1;
      model_inv   = model_inv + 32'd1;
      model_dir   = 1'b0;
      model_steps++;
      model_win--;
    end else if (d == 2) begin
      model_sticky = 1'b1;
      if (model_err < 255) model_err++;
    end
    model_ab = ab;
  endtask

  task automatic applyStimulus(input logic [1:0] ab, input int hold);
    quadA = ab[1];
    quadB = ab[0];
    repeat (hold) @(negedge clk);
    modelApply(ab);
  endtask

  task automatic loadCount(input logic [31:0] val);
    cnt_load     = 1'b1;
    cnt_load_val = val;
    @(negedge clk);
    cnt_load    = 1'b0;
    model_count = val;
    model_inv   = val;
    @(negedge clk);
  endtask

  task automatic waitVel(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (velv2 !== 1'b1 && n < 300);
  endtask

  initial begin
    logic [1:0] seq_fwd [4];
    int n;
    int op;
    int len;
    seq_fwd[0] = 2'b10; seq_fwd[1] = 2'b11; seq_fwd[2] = 2'b01; seq_fwd[3] = 2'b00;

    repeat (3) @(negedge clk);
    checkOutput("rst_count", count0, 32'd0);
    checkOutput("rst_dir", {31'd0, dir0}, 32'd0);
    checkOutput("rst_step", {31'd0, step0}, 32'd0);
    checkOutput("rst_idx", {31'd0, idx0}, 32'd0);
    checkOutput("rst_errs", {31'd0, errs0}, 32'd0);
    checkOutput("rst_errc", {24'd0, errc0}, 32'd0);
    checkOutput("rst_vel", {16'd0, vel0}, 32'd0);
    checkOutput("rst_velv", {31'd0, velv0}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] forward x10 with latency check");
    quadA = 1'b1;
    quadB = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("lat_before", count0, 32'd0);
    @(negedge clk);
    checkOutput("lat_after", count0, 32'd1);
    checkOutput("lat_step", {31'd0, step0}, 32'd1);
    repeat (3) @(negedge clk);
    modelApply(2'b10);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 4; j++)
        if (i != 0 || j != 0) applyStimulus(seq_fwd[j], 10);
    checkOutput("fwd_count", count0, 32'd40);
    checkOutput("fwd_dir", {31'd0, dir0}, 32'd1);
    checkOutput("fwd_steps", step_pulses, 32'd40);
    checkOutput("fwd_inv", count1, 32'hFFFF_FFD8);

    $display("[TB] reverse x8");
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) applyStimulus(seq_fwd[2 - j + ((j == 3) ? 4 : 0)], 10);
    checkOutput("rev_count", count0, 32'd8);
    checkOutput("rev_dir", {31'd0, dir0}, 32'd0);
    checkOutput("rev_inv", count1, 32'hFFFF_FFF8);

    $display("[TB] glitch filter");
    quadA = 1'b1;
    repeat (3) @(negedge clk);
    quadA = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("glitch3", count0, 32'd8);
    quadA = 1'b1;
    repeat (4) @(negedge clk);
    quadA = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pulse4_up", count0, 32'd9);
    repeat (10) @(negedge clk);
    checkOutput("pulse4_back", count0, 32'd8);
    modelApply(2'b10);
    modelApply(2'b00);

    $display("[TB] illegal transitions");
    applyStimulus(2'b11, 10);
    checkOutput("ill_count", count0, 32'd8);
    checkOutput("ill_errs", {31'd0, errs0}, 32'd1);
    checkOutput("ill_errc", {24'd0, errc0}, 32'd1);
    quadA = 1'b0;
    quadB = 1'b0;
    repeat (6) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("clr_ill_errc", {24'd0, errc0}, 32'd1);
    checkOutput("clr_ill_errs", {31'd0, errs0}, 32'd1);
    repeat (3) @(negedge clk);
    modelApply(2'b00);
    model_err = 1;

    $display("[TB] index and preload");
    loadCount(32'd123);
    checkOutput("load123", count0, 32'd123);
    idx_clr_en = 1'b1;
    quadI = 1'b1;
    quadA = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("idx_clr_count", count0, 32'd0);
    checkOutput("idx_clr_step", {31'd0, step0}, 32'd1);
    checkOutput("idx_clr_seen", {31'd0, idx0}, 32'd1);
    repeat (3) @(negedge clk);
    modelApply(2'b10);
    model_count = '0;
    model_inv = '0;
    model_idx++;
    quadI = 1'b0;
    repeat (8) @(negedge clk);
    quadI = 1'b1;
    repeat (6) @(negedge clk);
    cnt_load = 1'b1;
    cnt_load_val = 32'hFFFF_FFFB;
    @(negedge clk);
    cnt_load = 1'b0;
    checkOutput("load_vs_idx", count0, 32'hFFFF_FFFB);
    checkOutput("load_vs_idx_inv", count1, 32'hFFFF_FFFB);
    checkOutput("load_vs_idx_seen", {31'd0, idx0}, 32'd1);
    model_count = 32'hFFFF_FFFB;
    model_inv = 32'hFFFF_FFFB;
    model_idx++;
    repeat (3) @(negedge clk);
    quadI = 1'b0;
    repeat (8) @(negedge clk);
    idx_clr_en = 1'b0;

    $display("[TB] wrap");
    loadCount(32'h7FFF_FFFF);
    applyStimulus(2'b11, 10);
    checkOutput("wrap", count0, 32'h8000_0000);
    checkOutput("wrap_inv", count1, 32'h7FFF_FFFE);
    checkOutput("model_sync", count0, model_count);

    $display("[TB] velocity window");
    waitVel(n);
    checkOutput("vel_seen", {31'd0, velv2}, 32'd1);
    model_win = 0;
    for (int i = 0; i < 20; i++) applyStimulus(abAt(gpos(model_ab) + 1), 4);
    waitVel(n);
    checkOutput("vel_gap", n, 32'd20);
    checkOutput("vel_sat_pos", {28'd0, vel2}, {28'd0, clampVel(model_win)});
    checkOutput("vel_sat_pos_const", {28'd0, vel2}, 32'd7);
    model_win = 0;
    waitVel(n);
    checkOutput("vel_period", n, 32'd100);
    checkOutput("vel_zero", {28'd0, vel2}, {28'd0, clampVel(model_win)});
    model_win = 0;
    for (int i = 0; i < 20; i++) applyStimulus(abAt(gpos(model_ab) + 3), 4);
    waitVel(n);
    checkOutput("vel_sat_neg", {28'd0, vel2}, {28'd0, clampVel(model_win)});
    model_win = 0;
    for (int i = 0; i < 5; i++) applyStimulus(abAt(gpos(model_ab) + 1), 4);
    waitVel(n);
    checkOutput("vel_five", {28'd0, vel2}, {28'd0, clampVel(model_win)});

    $display("[TB] randomized run");
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        applyStimulus(abAt(gpos(model_ab) + (($urandom_range(0, 1) == 1) ? 1 : 3)),
                      $urandom_range(8, 15));
      end else if (op == 6) begin
        applyStimulus(abAt(gpos(model_ab) + 2), 10);
      end else if (op == 7) begin
        len = $urandom_range(1, 3);
        if ($urandom_range(0, 1) == 1) begin
          quadA = ~quadA;
          repeat (len) @(negedge clk);
          quadA = ~quadA;
        end else begin
          quadB = ~quadB;
          repeat (len) @(negedge clk);
          quadB = ~quadB;
        end
        repeat (8) @(negedge clk);
      end else if (op == 8) begin
        idx_clr_en = ($urandom_range(0, 1) == 1);
        quadI = 1'b1;
        repeat (6) @(negedge clk);
        quadI = 1'b0;
        repeat (6) @(negedge clk);
        model_idx++;
        if (idx_clr_en) begin
          model_count = '0;
          model_inv = '0;
        end
      end else begin
        loadCount($urandom);
      end
      checkOutput("rnd_count", count0, model_count);
      checkOutput("rnd_inv", count1, model_inv);
      checkOutput("rnd_dir", {31'd0, dir0}, {31'd0, model_dir});
      checkOutput("rnd_errc", {24'd0, errc0}, model_err);
    end
    checkOutput("tot_steps", step_pulses, model_steps);
    checkOutput("tot_idx", idx_pulses, model_idx);
    checkOutput("tot_errs", {31'd0, errs0}, {31'd0, model_sticky});

    rst_n = 1'b0;
    #1;
    checkOutput("rst2_count", count0, 32'd0);
    checkOutput("rst2_errc", {24'd0, errc0}, 32'd0);
    checkOutput("rst2_vel", {28'd0, vel2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
